chamber_controller: RTL

CHAMBER_CONTROLLER -- requirements
Module: chamber_controller

---
 rtl/chamber_controller.sv | 94 +++++++++
 1 files changed

// File: rtl/chamber_controller.sv
// rtl/chamber_controller.sv - two-port pressure chamber sequencer with timed fill/evacuate
module chamber_controller #(
   parameter int FILL_CYCLES = 7,
   parameter int EVAC_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       fill_req,
   input  logic       evac_req,
   input  logic       outer_closed,
   input  logic       inner_closed,
   output logic [1:0] state,
   output logic       busy,
   output logic       outer_ok,
   output logic       inner_ok,
   output logic [3:0] remaining,
   output logic       err,
   output logic       done
);

   typedef enum logic [1:0] {
      EMPTY      = 2'b00,
      FILLING    = 2'b01,
      FULL       = 2'b10,
      EVACUATING = 2'b11
   } chamber_state_t;

   chamber_state_t st;
   logic           ports_closed;
   logic           any_req;

   assign ports_closed = outer_closed & inner_closed;
   assign any_req      = fill_req | evac_req;
   assign state        = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= EMPTY;
         busy      <= 1'b0;
         outer_ok  <= 1'b1;
         inner_ok  <= 1'b0;
         remaining <= 4'd0;
         err       <= 1'b0;
         done      <= 1'b0;
      end else begin
         err  <= 1'b0;
         done <= 1'b0;
         case (st)
            EMPTY: begin
               if (fill_req && !evac_req && ports_closed) begin
                  st        <= FILLING;
                  remaining <= 4'(FILL_CYCLES);
                  busy      <= 1'b1;
                  outer_ok  <= 1'b0;
               end else if (any_req) begin
                  err <= 1'b1;
               end
            end
            FULL: begin
               if (evac_req && !fill_req && ports_closed) begin
                  st        <= EVACUATING;
                  remaining <= 4'(EVAC_CYCLES);
                  busy      <= 1'b1;
                  inner_ok  <= 1'b0;
               end else if (any_req) begin
                  err <= 1'b1;
               end
            end
            default: begin
               // Abort beats completion; on the completing edge done wins over a stray request
               if (!ports_closed) begin
                  st        <= (st == FILLING) ? EMPTY : FULL;
                  remaining <= 4'd0;
                  busy      <= 1'b0;
                  outer_ok  <= (st == FILLING);
                  inner_ok  <= (st == EVACUATING);
                  err       <= 1'b1;
               end else if (remaining <= 4'd1) begin
                  st        <= (st == FILLING) ? FULL : EMPTY;
                  remaining <= 4'd0;
                  busy      <= 1'b0;
                  outer_ok  <= (st == EVACUATING);
                  inner_ok  <= (st == FILLING);
                  done      <= 1'b1;
               end else begin
                  remaining <= remaining - 4'd1;
                  err       <= any_req;
               end
            end
         endcase
      end
   end

endmodule
